// File: rtl/battle_pkg.sv
// battle_pkg: shared cell/state encodings, board constants and the mod-5 helper.
package battle_pkg;
  localparam int BOARD_N = 5;
  localparam int SHIP_MAX = 5;
  localparam int TURN_TICKS = 15;
  typedef enum logic [1:0] {WATER, SHIP, MISS, HIT} cell_t;
  typedef enum logic [3:0] {IDLE, P_WAIT, P_WRITE, P_CHECK, PC_SEARCH, PC_WRITE, PC_CHECK, WIN, LOSE} turn_state_t;
  function automatic logic [2:0] mod5(input logic [2:0] v);
    return v >= 3'd5 ? v - 3'd5 : v;
  endfunction
endpackage

// File: rtl/turn_scheduler_if.sv
// turn_scheduler_if: player controls, board read/write port and status signals of the battle phase.
interface turn_scheduler_if;
  logic       start;
  logic [2:0] ships_total;
  logic       tick_1s;
  logic       player_fire;
  logic [2:0] player_i, player_j;
  logic [1:0] pc_cell_rd, pl_cell_rd;
  logic [2:0] pc_i, pc_j;
  logic       wr_en, wr_board;
  logic [2:0] wr_i, wr_j;
  logic [1:0] wr_val;
  logic       player_turn, pc_turn, victory, defeat;
  logic [3:0] turn_timer;
  logic       shot_error;
  modport master (
    output start, ships_total, tick_1s, player_fire, player_i, player_j, pc_cell_rd, pl_cell_rd,
    input  pc_i, pc_j, wr_en, wr_board, wr_i, wr_j, wr_val, player_turn, pc_turn, victory, defeat,
           turn_timer, shot_error
  );
  modport slave (
    input  start, ships_total, tick_1s, player_fire, player_i, player_j, pc_cell_rd, pl_cell_rd,
    output pc_i, pc_j, wr_en, wr_board, wr_i, wr_j, wr_val, player_turn, pc_turn, victory, defeat,
           turn_timer, shot_error
  );
endinterface

// File: rtl/pc_shot_gen.sv
// pc_shot_gen: free-running LFSR seeds a PC target, then a row-major wrap scan finds an unshot cell.
module pc_shot_gen
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_search,
  input  logic       search_en,
  input  logic       cell_free,
  output logic       found,
  output logic       exhausted,
  output logic [2:0] pc_i,
  output logic [2:0] pc_j
);
  logic [7:0] lfsr_q;
  logic [2:0] pc_i_q, pc_j_q;
  logic [4:0] cnt_q;
  logic       adv;
  assign found = search_en & cell_free;
  assign adv = search_en & ~cell_free;
  // 25 probes cover the whole board once, so the last one failing means no free cell
  assign exhausted = adv & (cnt_q == 5'd24);
  assign pc_i = pc_i_q;
  assign pc_j = pc_j_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
      pc_i_q <= '0;
      pc_j_q <= '0;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (start_search) begin
        pc_i_q <= mod5(lfsr_q[2:0]);
        pc_j_q <= mod5(lfsr_q[5:3]);
        cnt_q  <= '0;
      end else if (adv) begin
        pc_j_q <= pc_j_q == 3'(BOARD_N - 1) ? 3'd0 : pc_j_q + 3'd1;
        pc_i_q <= pc_j_q != 3'(BOARD_N - 1) ? pc_i_q : pc_i_q == 3'(BOARD_N - 1) ? 3'd0 : pc_i_q + 3'd1;
        cnt_q  <= cnt_q + 5'd1;
      end
    end
endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: battle-phase FSM alternating player and PC shots on one shared board write port.
module turn_scheduler
  import battle_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  turn_scheduler_if.slave bus
);
  turn_state_t state_q, state_d;
  logic [2:0] ships_q, pl_hits_q, pc_hits_q, wr_i_q, wr_j_q;
  logic [3:0] timer_q;
  cell_t      wr_val_q;
  logic       wr_en_q, wr_board_q, player_turn_q, pc_turn_q, victory_q, defeat_q, shot_err_q;
  logic       fire_ok, expire, start_search, found, exhausted;
  assign fire_ok = bus.player_fire & (bus.player_i < 3'(BOARD_N)) & (bus.player_j < 3'(BOARD_N)) & ~bus.pc_cell_rd[1];
  assign expire = bus.tick_1s & (timer_q == 4'd1);
  assign start_search = (state_d == PC_SEARCH) & (state_q != PC_SEARCH);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = bus.start ? P_WAIT : IDLE;
      P_WAIT:    state_d = fire_ok ? P_WRITE : expire ? PC_SEARCH : P_WAIT;
      P_WRITE:   state_d = P_CHECK;
      P_CHECK:   state_d = pl_hits_q == ships_q ? WIN : PC_SEARCH;
      PC_SEARCH: state_d = found ? PC_WRITE : exhausted ? LOSE : PC_SEARCH;
      PC_WRITE:  state_d = PC_CHECK;
      PC_CHECK:  state_d = pc_hits_q == ships_q ? LOSE : P_WAIT;
      default:   state_d = state_q;
    endcase
  end
  pc_shot_gen u_gen (
    .clk(clk), .rst_n(rst_n), .start_search(start_search), .search_en(state_q == PC_SEARCH),
    .cell_free(~bus.pl_cell_rd[1]), .found(found), .exhausted(exhausted), .pc_i(bus.pc_i), .pc_j(bus.pc_j)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ships_q <= '0;
      pl_hits_q <= '0;
      pc_hits_q <= '0;
      timer_q <= '0;
      wr_en_q <= 1'b0;
      wr_board_q <= 1'b0;
      wr_i_q <= '0;
      wr_j_q <= '0;
      wr_val_q <= WATER;
      player_turn_q <= 1'b0;
      pc_turn_q <= 1'b0;
      victory_q <= 1'b0;
      defeat_q <= 1'b0;
      shot_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      player_turn_q <= state_d == P_WAIT;
      pc_turn_q <= state_d == PC_SEARCH;
      victory_q <= victory_q | (state_d == WIN);
      defeat_q <= defeat_q | (state_d == LOSE);
      wr_en_q <= 1'b0;
      shot_err_q <= (state_q == P_WAIT) & bus.player_fire & ~fire_ok;
      if (state_q == IDLE && bus.start)
        ships_q <= bus.ships_total == 3'd0 ? 3'd1 : bus.ships_total > 3'(SHIP_MAX) ? 3'(SHIP_MAX) : bus.ships_total;
      // every entry into P_WAIT starts a fresh turn; ticks only count down while waiting
      if (state_d == P_WAIT && state_q != P_WAIT) timer_q <= 4'(TURN_TICKS);
      else if (state_q == P_WAIT && bus.tick_1s && timer_q != 4'd0) timer_q <= timer_q - 4'd1;
      if (state_q == P_WAIT && fire_ok) begin
        wr_en_q <= 1'b1;
        wr_board_q <= 1'b1;
        wr_i_q <= bus.player_i;
        wr_j_q <= bus.player_j;
        wr_val_q <= bus.pc_cell_rd[0] ? HIT : MISS;
      end
      if (state_q == PC_SEARCH && found) begin
        wr_en_q <= 1'b1;
        wr_board_q <= 1'b0;
        wr_i_q <= bus.pc_i;
        wr_j_q <= bus.pc_j;
        wr_val_q <= bus.pl_cell_rd[0] ? HIT : MISS;
      end
      if (state_q == P_WRITE && wr_val_q == HIT && pl_hits_q < 3'(SHIP_MAX)) pl_hits_q <= pl_hits_q + 3'd1;
      if (state_q == PC_WRITE && wr_val_q == HIT && pc_hits_q < 3'(SHIP_MAX)) pc_hits_q <= pc_hits_q + 3'd1;
    end
  assign bus.wr_en = wr_en_q;
  assign bus.wr_board = wr_board_q;
  assign bus.wr_i = wr_i_q;
  assign bus.wr_j = wr_j_q;
  assign bus.wr_val = wr_val_q;
  assign bus.player_turn = player_turn_q;
  assign bus.pc_turn = pc_turn_q;
  assign bus.victory = victory_q;
  assign bus.defeat = defeat_q;
  assign bus.turn_timer = timer_q;
  assign bus.shot_error = shot_err_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed battle scenarios against hand-computed expectations.
module tb_turn_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] pc_board [25];
  logic [1:0] pl_board [25];
  turn_scheduler_if bus ();
  turn_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.pc_cell_rd = (bus.player_i < 3'd5 && bus.player_j < 3'd5) ? pc_board[int'(bus.player_i) * 5 + int'(bus.player_j)] : 2'b00;
  assign bus.pl_cell_rd = (bus.pc_i < 3'd5 && bus.pc_j < 3'd5) ? pl_board[int'(bus.pc_i) * 5 + int'(bus.pc_j)] : 2'b11;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic fire(input int i, input int j, input logic tick);
    bus.player_i = 3'(i);
    bus.player_j = 3'(j);
    bus.player_fire = 1'b1;
    bus.tick_1s = tick;
    step();
    bus.player_fire = 1'b0;
    bus.tick_1s = 1'b0;
  endtask
  task automatic tick_once();
    bus.tick_1s = 1'b1;
    step();
    bus.tick_1s = 1'b0;
  endtask
  task automatic start_game(input int ships);
    bus.ships_total = 3'(ships);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_player();
    int k = 0;
    while (!bus.player_turn && k < 40) begin
      step();
      k++;
    end
    check("back_to_player", int'(bus.player_turn), 1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ships_total = 3'd0;
    bus.tick_1s = 1'b0;
    bus.player_fire = 1'b0;
    bus.player_i = 3'd0;
    bus.player_j = 3'd0;
    for (int k = 0; k < 25; k++) begin
      pc_board[k] = 2'b00;
      pl_board[k] = 2'b00;
    end
    pc_board[13] = 2'b01;
    pc_board[0] = 2'b01;
    pc_board[6] = 2'b01;
    step(2);
    check("rst_player_turn", int'(bus.player_turn), 0);
    check("rst_pc_turn", int'(bus.pc_turn), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_timer", int'(bus.turn_timer), 0);
    check("rst_flags", int'({bus.victory, bus.defeat, bus.shot_error}), 0);
    check("rst_pc_ij", int'({bus.pc_i, bus.pc_j}), 0);
    rst_n = 1'b1;
    step();
    start_game(3);
    check("start_player_turn", int'(bus.player_turn), 1);
    check("start_timer", int'(bus.turn_timer), 15);
    check("start_pc_turn", int'(bus.pc_turn), 0);
    check("start_wr_en", int'(bus.wr_en), 0);
    fire(2, 3, 1'b0);
    check("hit_wr_en", int'(bus.wr_en), 1);
    check("hit_wr_board", int'(bus.wr_board), 1);
    check("hit_wr_i", int'(bus.wr_i), 2);
    check("hit_wr_j", int'(bus.wr_j), 3);
    check("hit_wr_val", int'(bus.wr_val), 3);
    step();
    check("check_wr_en", int'(bus.wr_en), 0);
    step();
    check("n3_pc_turn", int'(bus.pc_turn), 1);
    check("n3_player_turn", int'(bus.player_turn), 0);
    pc_board[13] = 2'b11;
    wait_player();
    check("reload_timer", int'(bus.turn_timer), 15);
    fire(2, 3, 1'b0);
    check("err_hit_pulse", int'(bus.shot_error), 1);
    check("err_hit_wr_en", int'(bus.wr_en), 0);
    step();
    check("err_pulse_end", int'(bus.shot_error), 0);
    fire(5, 0, 1'b0);
    check("err_oob_pulse", int'(bus.shot_error), 1);
    check("err_oob_wr_en", int'(bus.wr_en), 0);
    check("err_still_wait", int'(bus.player_turn), 1);
    check("err_timer", int'(bus.turn_timer), 15);
    step();
    for (int k = 1; k <= 15; k++) begin
      tick_once();
      check("tick_timer", int'(bus.turn_timer), 15 - k);
      if (k < 15) begin
        check("tick_still_player", int'(bus.player_turn), 1);
        step();
      end
    end
    check("timeout_pc_turn", int'(bus.pc_turn), 1);
    wait_player();
    for (int k = 1; k <= 14; k++) begin
      tick_once();
      step();
    end
    check("pre_expire_timer", int'(bus.turn_timer), 1);
    fire(0, 0, 1'b1);
    check("coinc_wr_en", int'(bus.wr_en), 1);
    check("coinc_wr_ij", int'({bus.wr_i, bus.wr_j}), 0);
    check("coinc_wr_val", int'(bus.wr_val), 3);
    pc_board[0] = 2'b11;
    step(2);
    wait_player();
    fire(1, 1, 1'b0);
    check("win_shot_wr_val", int'(bus.wr_val), 3);
    step(2);
    check("victory", int'(bus.victory), 1);
    check("win_turns", int'({bus.player_turn, bus.pc_turn}), 0);
    start_game(3);
    step(5);
    check("victory_sticky", int'(bus.victory), 1);
    check("win_start_ignored", int'(bus.player_turn), 0);
    do_reset();
    check("reset_clears_victory", int'(bus.victory), 0);
    pc_board[0] = 2'b01;
    start_game(3);
    fire(0, 0, 1'b0);
    check("midwrite_wr_en", int'(bus.wr_en), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", int'(bus.wr_en), 0);
    check("async_rst_timer", int'(bus.turn_timer), 0);
    check("async_rst_turns", int'({bus.player_turn, bus.pc_turn, bus.victory, bus.defeat}), 0);
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 25; k++) pl_board[k] = (k % 3 == 0) ? 2'b11 : 2'b10;
    pl_board[24] = 2'b01;
    start_game(0);
    fire(3, 3, 1'b0);
    check("miss_wr_val", int'(bus.wr_val), 2);
    begin
      int k = 0;
      while (!(bus.wr_en && !bus.wr_board) && k < 40) begin
        step();
        k++;
      end
    end
    check("pc_write_seen", int'(bus.wr_en && !bus.wr_board), 1);
    check("pc_wr_i", int'(bus.wr_i), 4);
    check("pc_wr_j", int'(bus.wr_j), 4);
    check("pc_wr_val", int'(bus.wr_val), 3);
    step(2);
    check("defeat", int'(bus.defeat), 1);
    check("defeat_no_victory", int'(bus.victory), 0);
    step(10);
    check("defeat_sticky", int'(bus.defeat), 1);
    check("defeat_no_write", int'(bus.wr_en), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Sequences the battle phase once ship placement is finished.
- Alternates player and PC turns and arbitrates the single shared board write port between the two shooters.
- Runs the per-turn timeout and generates the PC's shot via LFSR-seeded scan.
- Detects victory/defeat and feeds status to the VGA and 7-segment paths.

Parameters:
- BOARD_N, 5: board dimension (rows = cols).
- TURN_TICKS, 15: seconds allowed per player turn.
- SHIP_MAX, 5: maximum ship cell count.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- start  in  1  1-cycle pulse: placement finished; begin battle.
- ships_total  in  3  ship cells per side; latched on start.
- tick_1s  in  1  1-cycle pulse once per second.
- player_fire  in  1  1-cycle pulse: player shoots at player_i/player_j.
- player_i, player_j  in  3 each  player cursor row/col.
- pc_cell_rd  in  2  PC board cell at (player_i, player_j); combinational read.
- pl_cell_rd  in  2  player board cell at (pc_i, pc_j); combinational read.
- pc_i, pc_j  out  3 each  PC target row/col.
- wr_en  out  1  board write strobe.
- wr_board  out  1  write target: 0 = player board, 1 = PC board.
- wr_i, wr_j  out  3 each  write address.
- wr_val  out  2  value written.
- player_turn, pc_turn  out  1 each  turn indicators.
- victory, defeat  out  1 each  sticky result flags.
- turn_timer  out  4  seconds remaining in player turn.
- shot_error  out  1  1-cycle pulse: illegal player shot.

Behaviour:
- Cell encoding: 00 water, 01 ship, 10 miss, 11 hit. A shot on 00 writes 10; a shot on 01 writes 11.
- Reset (any time, including mid-turn): state IDLE; all outputs 0; hit counters 0; LFSR = 8'hA5. Reset overrides every other input.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Free-runs every cycle outside reset.
- IDLE: on start, latch ships_total, clamped to 1..SHIP_MAX (0 becomes 1, >5 becomes 5). Load turn_timer = TURN_TICKS and go to P_WAIT. start is ignored in every other state.
- P_WAIT (player_turn = 1):
  - tick_1s decrements turn_timer.
  - If a tick finds turn_timer = 1, it reaches 0: the turn is forfeited and the FSM goes to PC_SEARCH.
  - player_fire is illegal if i ≥ 5, j ≥ 5, or pc_cell_rd[1] = 1. Illegal fire pulses shot_error for 1 cycle, stays in P_WAIT, timer not reloaded.
  - Legal fire: latch coordinates and result, go to P_WRITE.
  - player_fire and the expiring tick in the same cycle: the fire wins.
- P_WRITE: for 1 cycle, wr_en = 1, wr_board = 1, wr_i/wr_j = latched coordinates, wr_val = result. A hit increments player_hits. Next state P_CHECK.
- P_CHECK: if player_hits == ships_total, go to WIN; else go to PC_SEARCH.
- Player-shot latency: fire sampled at cycle N, write at N+1, check at N+2, PC_SEARCH entered at N+3.
- PC_SEARCH (pc_turn = 1):
  - On entry: pc_i = lfsr[2:0] mod 5, pc_j = lfsr[5:3] mod 5.
  - Each cycle: if pl_cell_rd[1] = 0, go to PC_WRITE.
  - Otherwise advance pc_j; when pc_j wraps 4→0, pc_i also advances, wrapping 4→0.
  - Search is bounded at 25 cycles. If no cell is found, go to LOSE; this is unreachable in legal play.
- PC_WRITE: for 1 cycle, wr_en = 1, wr_board = 0, address = pc_i/pc_j, wr_val per encoding. A hit increments pc_hits. Next state PC_CHECK.
- PC_CHECK: if pc_hits == ships_total, go to LOSE; else reload turn_timer = TURN_TICKS and go to P_WAIT.
- WIN: victory = 1. LOSE: defeat = 1. Both are sticky until reset; turn outputs are 0 in both.
- wr_en is asserted only in P_WRITE and PC_WRITE, never in any other state. Only one writer can drive the port at a time.
- Hit counters are 3 bits and saturate at SHIP_MAX.

Decomposition:
- Shared package battle_pkg:
  - cell_t enum: WATER, SHIP, MISS, HIT.
  - turn_state_t enum: IDLE, P_WAIT, P_WRITE, P_CHECK, PC_SEARCH, PC_WRITE, PC_CHECK, WIN, LOSE.
  - Constants BOARD_N and SHIP_MAX.
- One sub-module: pc_shot_gen, containing the LFSR, the mod-5 seed and the wrap-scan counters. Its interface is start_search, cell_free, found, pc_i, pc_j.

Test Plan:
- Reset then start with ships_total = 3: P_WAIT, player_turn = 1, turn_timer = 15, all other outputs 0.
- Legal fire on (2,3) with pc_cell_rd = 01: at N+1, wr_en = 1, wr_board = 1, wr_i = 2, wr_j = 3, wr_val = 11; at N+3, pc_turn = 1.
- Fire on an already-hit cell (pc_cell_rd = 11), then fire on (5,0): two shot_error pulses, no wr_en, still P_WAIT, timer unchanged.
- 15 tick_1s pulses with no fire: turn_timer counts 15→0 and pc_turn = 1 after the 15th tick. Repeat with fire coincident with the 15th tick: the shot is written.
- PC search with the player board all 10/11 except cell (4,4) = 01: PC writes 11 at (4,4) within 25 cycles. With ships_total = 1 this gives defeat = 1 (sticky).
- Three player hits with ships_total = 3, and a reset asserted mid-P_WRITE on a separate run: first gives victory = 1; reset immediately gives IDLE with all outputs 0.
